pipe_reg_elastic: RTL and testbench
===================================

Name: pipe_reg_elastic

Overview:
- Parametrised successor to the team's 8-bit reset-able data register: a WIDTH-bit, DEPTH-stage register pipeline with valid/ready flow control.
- Bubbles collapse, so any empty stage can be filled while downstream stages stall.
- Sits between datapath blocks as a timing-closure / retiming stage with a registered output and occupancy reporting.

Parameters:
- WIDTH, 8, data width in bits (>=1).
- DEPTH, 2, number of register stages (>=1); also the maximum number of words held.
- RST_VAL, 0, value loaded into every stage data register on reset.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  WIDTH  upstream data.
- in_valid  input  1  upstream word present.
- in_ready  output  1  pipeline accepts in_data this cycle (combinational).
- out_data  output  WIDTH  data of final stage (registered).
- out_valid  output  1  final stage holds a word (registered).
- out_ready  input  1  downstream accepts out_data this cycle.
- count  output  $clog2(DEPTH+1)  number of valid words held (registered).

Behaviour:
- Stages are S[0]..S[DEPTH-1]; each has data d[i] and valid v[i]. out_data=d[DEPTH-1], out_valid=v[DEPTH-1].
- Reset (async, rst=1): all v[i]=0, all d[i]=RST_VAL, count=0. Therefore out_valid=0 and out_data=RST_VAL. Asserted mid-operation, all held words are discarded immediately.
- Advance terms (combinational):
  - adv[DEPTH-1] = v[DEPTH-1] & out_ready.
  - adv[i] = v[i] & take[i+1], for i < DEPTH-1.
  - take[i] = ~v[i] | adv[i].
  - in_ready = take[0].
- Ready path: in_ready depends combinationally on out_ready through the chain. This is intended; no skid buffer.
- Per clock edge, for stage i:
  - If take[i]: load from predecessor. d[i] <= in_data and v[i] <= in_valid for i=0; otherwise d[i] <= d[i-1] and v[i] <= v[i-1]&adv[i-1].
  - Else: hold.
  - d[i] updates only when the incoming valid is 1; otherwise data holds and only v clears.
- Input transfer occurs when in_valid & in_ready. Output transfer occurs when out_valid & out_ready.
- Latency: with no stalls, a word accepted at edge t appears on out_data/out_valid after edge t+DEPTH-1, i.e. DEPTH cycles after in_valid is presented. DEPTH=1 is a single registered stage.
- Throughput: one word per cycle sustained while out_ready=1.
- Full (count==DEPTH) with out_ready=0: in_ready=0. Full with out_ready=1: in_ready=1, so a simultaneous in/out transfer occurs.
- Empty: out_valid=0. out_ready is ignored.
- Bubbles: if v[DEPTH-1]=1 and out_ready=0, upstream stages still advance into empty slots until all are full.
- count update:
  - +1 on input transfer only.
  - -1 on output transfer only.
  - Unchanged if both or neither occur.
  - Never exceeds DEPTH; never wraps below 0.
- Ordering: words leave strictly in acceptance order; no word is duplicated or dropped.
- No X on outputs after reset regardless of the in_data value while in_valid=0.

Optional Feature:
- Macro PIPE_REG_FLUSH_EN.
- Defined: adds input port flush (1 bit, synchronous, active-high).
  - When flush=1 at an edge, all v[i] <= 0 and count <= 0. d[i] holds.
  - in_ready is forced to 0 during flush, so no input transfer occurs and in_data is dropped.
  - An output transfer occurring that cycle (out_valid & out_ready) still counts as delivered.
  - rst has priority over flush.
- Undefined: no flush port. Behaviour as above; only rst clears the pipeline.

Test Plan:
- Reset: DEPTH=3, WIDTH=8, RST_VAL=8'hA5, assert rst asynchronously between edges -> out_valid=0, out_data=8'hA5, count=0 immediately, before the next edge.
- Streaming: out_ready=1, present 0x01..0x10 back-to-back -> out_data=0x01 valid 3 cycles after first presentation, then one word per cycle in order; in_ready stays 1; count stays 3 during steady state.
- Backpressure: out_ready=0, push 0x11,0x22,0x33,0x44 -> first three accepted, count=3, in_ready=0 on the 4th. Raise out_ready with 0x44 still valid -> 0x11 out and 0x44 in on the same edge, count stays 3.
- Bubble collapse: DEPTH=4, one word in S[3] with out_ready=0, input idle 2 cycles, then push 3 words -> all 3 accepted consecutively, count=4.
- Reset mid-stream: count=2 with words 0x5A,0x5B held, pulse rst -> count=0, out_valid=0. The next pushed 0x77 is the first word out.
- Flush (PIPE_REG_FLUSH_EN defined): count=3, out_ready=1, flush=1 with in_valid=1 (0x99) -> current out_data word delivered, 0x99 not accepted, count=0 next cycle, out_valid=0.

Source files
------------

// File: rtl/pipe_reg_elastic.sv
// rtl/pipe_reg_elastic.sv - elastic WIDTH x DEPTH register pipeline with valid/ready; optional macro PIPE_REG_FLUSH_EN adds a flush input
module pipe_reg_elastic #(
  parameter int               WIDTH   = 8,
  parameter int               DEPTH   = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst,
`ifdef PIPE_REG_FLUSH_EN
  input  logic                       flush,
`endif
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] r_d [DEPTH];
  logic [DEPTH-1:0] r_v;
  logic [CW-1:0]    r_count;

  logic [DEPTH-1:0] w_adv;
  logic [DEPTH-1:0] w_take;
  logic             w_flush;
  logic             w_in_xfer;
  logic             w_out_xfer;

`ifdef PIPE_REG_FLUSH_EN
  assign w_flush = flush;
`else
  assign w_flush = 1'b0;
`endif

  // Advance/take chain from the output back to the input; a stage can take
  // a word when it is empty or its own word moves on this cycle.
  always_comb begin
    w_adv            = '0;
    w_take           = '0;
    w_adv[DEPTH-1]   = r_v[DEPTH-1] & out_ready;
    w_take[DEPTH-1]  = ~r_v[DEPTH-1] | w_adv[DEPTH-1];
    for (int i = DEPTH - 2; i >= 0; i--) begin
      w_adv[i]  = r_v[i] & w_take[i+1];
      w_take[i] = ~r_v[i] | w_adv[i];
    end
  end

  assign in_ready   = w_take[0] & ~w_flush;
  assign w_in_xfer  = in_valid & in_ready;
  assign w_out_xfer = r_v[DEPTH-1] & out_ready;

  // Stage registers: load from predecessor when taking; data only moves with a valid word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_d[i] <= RST_VAL;
      end
    end else if (w_flush) begin
      r_v <= '0;
    end else begin
      if (w_take[0]) begin
        r_v[0] <= in_valid;
        if (in_valid) begin
          r_d[0] <= in_data;
        end
      end
      for (int i = 1; i < DEPTH; i++) begin
        if (w_take[i]) begin
          r_v[i] <= w_adv[i-1];
          if (w_adv[i-1]) begin
            r_d[i] <= r_d[i-1];
          end
        end
      end
    end
  end

  // Occupancy: up on input-only transfer, down on output-only transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (w_flush) begin
      r_count <= '0;
    end else if (w_in_xfer && !w_out_xfer) begin
      r_count <= r_count + CW'(1);
    end else if (w_out_xfer && !w_in_xfer) begin
      r_count <= r_count - CW'(1);
    end
  end

  assign out_data  = r_d[DEPTH-1];
  assign out_valid = r_v[DEPTH-1];
  assign count     = r_count;

endmodule

// File: tb/tb_pipe_reg_elastic.sv
// tb/tb_pipe_reg_elastic.sv - randomized and directed bench for pipe_reg_elastic against a word-position queue model
module tb_pipe_reg_elastic;

  localparam int         WIDTH   = 8;
  localparam int         DEPTH   = 3;
  localparam logic [7:0] RST_VAL = 8'hA5;

  logic       clk;
  logic       rst;
  logic       flush;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] count;

  int n_tests = 0;
  int n_fail  = 0;

  // model: oldest word first, with its current stage index
  int         q_pos[$];
  logic [7:0] q_dat[$];
  logic [7:0] m_end;

  pipe_reg_elastic #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RST_VAL(RST_VAL)) dut (
    .clk       (clk),
`ifdef PIPE_REG_FLUSH_EN
    .flush     (flush),
`endif
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_leave(input bit ordy);
    return (q_pos.size() > 0) && (q_pos[0] == DEPTH - 1) && ordy;
  endfunction

  // A word moves one stage if the slot ahead is free after the words ahead have moved.
  function automatic bit m_rdy(input bit ordy, input bit fl);
    int lim;
    int np;
    lim = DEPTH - 1;
    for (int k = (m_leave(ordy) ? 1 : 0); k < q_pos.size(); k++) begin
      np  = (q_pos[k] + 1 < lim) ? q_pos[k] + 1 : lim;
      lim = np - 1;
    end
    return !fl && (lim >= 0);
  endfunction

  function automatic bit m_valid();
    return (q_pos.size() > 0) && (q_pos[0] == DEPTH - 1);
  endfunction

  task automatic m_commit(input bit iv, input logic [7:0] id, input bit ordy, input bit fl);
    bit rdy;
    int lim;
    int np;
    rdy = m_rdy(ordy, fl);
    if (fl) begin
      q_pos.delete();
      q_dat.delete();
      return;
    end
    if (m_leave(ordy)) begin
      void'(q_pos.pop_front());
      void'(q_dat.pop_front());
    end
    lim = DEPTH - 1;
    for (int k = 0; k < q_pos.size(); k++) begin
      np = (q_pos[k] + 1 < lim) ? q_pos[k] + 1 : lim;
      if (np == DEPTH - 1 && q_pos[k] != DEPTH - 1) m_end = q_dat[k];
      q_pos[k] = np;
      lim = np - 1;
    end
    if (iv && rdy) begin
      q_pos.push_back(0);
      q_dat.push_back(id);
      if (DEPTH - 1 == 0) m_end = id;
    end
  endtask

  task automatic m_reset();
    q_pos.delete();
    q_dat.delete();
    m_end = RST_VAL;
  endtask

  // One clock: drive at negedge, check just after, model steps at posedge.
  task automatic cycle(input bit iv, input logic [7:0] id, input bit ordy, input bit fl);
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    flush     = fl;
    #1;
    chk("in_ready",  in_ready,  m_rdy(ordy, fl));
    chk("out_valid", out_valid, m_valid());
    chk("out_data",  out_data,  m_end);
    chk("count",     count,     q_pos.size());
    @(posedge clk);
    m_commit(iv, id, ordy, fl);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data",  out_data,  RST_VAL);
    chk("rst_count",     count,     0);
    m_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < DEPTH + 1; k++) cycle(1'b0, 8'($urandom), 1'b1, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
    m_reset();
    @(negedge clk);
    do_reset();

    // streaming 0x01..0x10
    for (int k = 0; k < 16; k++) begin
      cycle(1'b1, 8'(k + 1), 1'b1, 1'b0);
      if (k >= 2) begin
        #1;
        chk("stream_data",  out_data,  k - 1);
        chk("stream_valid", out_valid, 1);
        chk("stream_count", count,     3);
      end
    end
    drain();

    // backpressure
    cycle(1'b1, 8'h11, 1'b0, 1'b0);
    cycle(1'b1, 8'h22, 1'b0, 1'b0);
    cycle(1'b1, 8'h33, 1'b0, 1'b0);
    #1;
    chk("bp_full_count", count, 3);
    chk("bp_full_data",  out_data, 8'h11);
    cycle(1'b1, 8'h44, 1'b0, 1'b0);
    cycle(1'b1, 8'h44, 1'b1, 1'b0);
    #1;
    chk("bp_swap_count", count, 3);
    chk("bp_swap_data",  out_data, 8'h22);
    drain();

    // bubble collapse
    cycle(1'b1, 8'hB0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) cycle(1'b0, 8'($urandom), 1'b0, 1'b0);
    cycle(1'b1, 8'hB1, 1'b0, 1'b0);
    cycle(1'b1, 8'hB2, 1'b0, 1'b0);
    #1;
    chk("bubble_count", count, 3);
    chk("bubble_data",  out_data, 8'hB0);
    drain();

    // reset mid-stream
    cycle(1'b1, 8'h5A, 1'b0, 1'b0);
    cycle(1'b1, 8'h5B, 1'b0, 1'b0);
    #1;
    chk("mid_count", count, 2);
    do_reset();
    cycle(1'b1, 8'h77, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    #1;
    chk("mid_first_valid", out_valid, 1);
    chk("mid_first_data",  out_data, 8'h77);
    drain();

`ifdef PIPE_REG_FLUSH_EN
    cycle(1'b1, 8'hF1, 1'b0, 1'b0);
    cycle(1'b1, 8'hF2, 1'b0, 1'b0);
    cycle(1'b1, 8'hF3, 1'b0, 1'b0);
    cycle(1'b1, 8'h99, 1'b1, 1'b1);
    #1;
    chk("flush_count", count, 0);
    chk("flush_valid", out_valid, 0);
    drain();
`endif

    // randomized phases with varying input/output duty
    for (int ph = 0; ph < 8; ph++) begin
      int pv;
      int pr;
      pv = $urandom_range(10, 100);
      pr = $urandom_range(10, 100);
      for (int k = 0; k < 300; k++) begin
        bit fl;
        fl = 1'b0;
`ifdef PIPE_REG_FLUSH_EN
        fl = ($urandom_range(0, 49) == 0);
`endif
        cycle($urandom_range(0, 99) < pv, 8'($urandom), $urandom_range(0, 99) < pr, fl);
      end
      if (ph == 4) do_reset();
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
